// File: rtl/sobel_stream_filter.sv
// Streaming 3x3 Sobel edge filter over raster-order pixels with a valid/ready
// handshake on both sides; emits interior pixels only.
module sobel_stream_filter #(
  parameter int IMG_WIDTH  = 64,
  parameter int IMG_HEIGHT = 64,
  parameter int PIX_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [PIX_W-1:0] in_pix,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       mode,
  output logic [PIX_W-1:0] out_pix,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last
);

  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  localparam int GW = PIX_W + 4;

  logic [CW-1:0]    col_reg;
  logic [RW-1:0]    row_reg;
  logic [1:0]       mode_reg;
  logic             adv;
  logic             accept;

  logic [PIX_W-1:0] line0 [IMG_WIDTH];
  logic [PIX_W-1:0] line1 [IMG_WIDTH];

  logic             s1_valid_reg;
  logic             s1_done_reg;
  logic             s1_last_reg;
  logic [CW-1:0]    s1_col_reg;
  logic [PIX_W-1:0] s1_pix_reg;
  logic [PIX_W-1:0] s1_up1_reg;
  logic [PIX_W-1:0] s1_up2_reg;

  logic [PIX_W-1:0] hist_reg [3][2];
  logic [PIX_W-1:0] col_new  [3];
  logic [PIX_W-1:0] win_next [3][3];

  logic             out_valid_reg;
  logic             out_last_reg;
  logic [PIX_W-1:0] out_pix_reg;

  // The whole pipeline moves together; only a refused output freezes it.
  assign in_ready = !(out_valid_reg && !out_ready);
  assign adv      = in_ready;
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      col_reg  <= '0;
      row_reg  <= '0;
      mode_reg <= 2'd0;
    end else if (accept) begin
      if (col_reg == '0 && row_reg == '0)
        mode_reg <= mode;
      if (col_reg == CW'(IMG_WIDTH - 1)) begin
        col_reg <= '0;
        row_reg <= (row_reg == RW'(IMG_HEIGHT - 1)) ? '0 : row_reg + 1'b1;
      end else begin
        col_reg <= col_reg + 1'b1;
      end
    end
  end

  // Line buffers: line0 holds the previous row, line1 the row before that.
  always_ff @(posedge clk) begin
    if (accept) begin
      line0[col_reg] <= in_pix;
      s1_up1_reg     <= line0[col_reg];
    end
  end

  always_ff @(posedge clk) begin
    if (accept)
      s1_up2_reg <= line1[col_reg];
    if (s1_valid_reg && adv)
      line1[s1_col_reg] <= s1_up1_reg;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_reg <= 1'b0;
    end else if (adv) begin
      s1_valid_reg <= accept;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      s1_pix_reg  <= in_pix;
      s1_col_reg  <= col_reg;
      s1_done_reg <= (row_reg >= RW'(2)) && (col_reg >= CW'(2));
      s1_last_reg <= (row_reg == RW'(IMG_HEIGHT - 1)) && (col_reg == CW'(IMG_WIDTH - 1));
    end
  end

  assign col_new[0] = s1_up2_reg;
  assign col_new[1] = s1_up1_reg;
  assign col_new[2] = s1_pix_reg;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_win
      assign win_next[gi][0] = hist_reg[gi][0];
      assign win_next[gi][1] = hist_reg[gi][1];
      assign win_next[gi][2] = col_new[gi];
      always_ff @(posedge clk) begin
        if (s1_valid_reg && adv) begin
          hist_reg[gi][0] <= hist_reg[gi][1];
          hist_reg[gi][1] <= col_new[gi];
        end
      end
    end
  endgenerate

  function automatic logic signed [GW-1:0] ext(input logic [PIX_W-1:0] v);
    return $signed({4'b0000, v});
  endfunction

  function automatic logic [PIX_W-1:0] sat(input logic [GW-1:0] v);
    if (v > {4'b0000, {PIX_W{1'b1}}})
      return {PIX_W{1'b1}};
    return v[PIX_W-1:0];
  endfunction

  logic signed [GW-1:0] gx;
  logic signed [GW-1:0] gy;
  logic        [GW-1:0] abs_gx;
  logic        [GW-1:0] abs_gy;
  logic        [GW-1:0] abs_sum;
  logic [PIX_W-1:0]     result;

  assign gx = (ext(win_next[0][2]) + (ext(win_next[1][2]) <<< 1) + ext(win_next[2][2]))
            - (ext(win_next[0][0]) + (ext(win_next[1][0]) <<< 1) + ext(win_next[2][0]));
  assign gy = (ext(win_next[2][0]) + (ext(win_next[2][1]) <<< 1) + ext(win_next[2][2]))
            - (ext(win_next[0][0]) + (ext(win_next[0][1]) <<< 1) + ext(win_next[0][2]));
  assign abs_gx  = gx[GW-1] ? $unsigned(-gx) : $unsigned(gx);
  assign abs_gy  = gy[GW-1] ? $unsigned(-gy) : $unsigned(gy);
  assign abs_sum = abs_gx + abs_gy;

  always_comb begin
    result = '0;
    case (mode_reg)
      2'd0:    result = sat(abs_gx);
      2'd1:    result = sat(abs_gy);
      2'd2:    result = sat(abs_sum);
      default: result = win_next[1][1];
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_reg <= 1'b0;
      out_last_reg  <= 1'b0;
      out_pix_reg   <= '0;
    end else if (adv) begin
      out_valid_reg <= s1_valid_reg && s1_done_reg;
      out_last_reg  <= s1_valid_reg && s1_done_reg && s1_last_reg;
      if (s1_valid_reg && s1_done_reg)
        out_pix_reg <= result;
    end
  end

  assign out_valid = out_valid_reg;
  assign out_last  = out_last_reg;
  assign out_pix   = out_pix_reg;

endmodule

// File: tb/tb_sobel_stream_filter.sv
// Bench for sobel_stream_filter: an image-level Sobel model feeds an expected
// output queue that a single monitor compares against every output transfer.
module tb_sobel_stream_filter;

  localparam int W = 64;
  localparam int H = 64;
  localparam int NOUT = (W - 2) * (H - 2);

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_pix;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] mode;
  logic [7:0] out_pix;
  logic       out_valid;
  logic       out_ready;
  logic       out_last;

  sobel_stream_filter #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .PIX_W(8)) dut (
    .clk(clk), .rst(rst), .in_pix(in_pix), .in_valid(in_valid), .in_ready(in_ready),
    .mode(mode), .out_pix(out_pix), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int tests = 0;
  int fails = 0;

  typedef struct { int pix; int last; } exp_t;
  exp_t exp_q[$];
  int   lat_q[$];
  bit   strict_q[$];
  bit   strict = 1'b1;
  int   trow = 0, tcol = 0, out_cnt = 0;
  bit   prev_stall = 1'b0;
  int   prev_word = 0;
  logic [7:0] img [H][W];

  task automatic check(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Image-level Sobel around centre (r,c).
  function automatic int sobel(input int m, input int r, input int c);
    int p [3][3];
    int gx, gy, v;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        p[i][j] = int'(img[r - 1 + i][c - 1 + j]);
    gx = (p[0][2] + 2 * p[1][2] + p[2][2]) - (p[0][0] + 2 * p[1][0] + p[2][0]);
    gy = (p[2][0] + 2 * p[2][1] + p[2][2]) - (p[0][0] + 2 * p[0][1] + p[0][2]);
    if (gx < 0) gx = -gx;
    if (gy < 0) gy = -gy;
    case (m)
      0: v = gx;
      1: v = gy;
      2: v = gx + gy;
      default: v = p[1][1];
    endcase
    return (v > 255) ? 255 : v;
  endfunction

  task automatic build_expected(input int m);
    exp_t e;
    for (int r = 1; r <= H - 2; r++)
      for (int c = 1; c <= W - 2; c++) begin
        e.pix  = sobel(m, r, c);
        e.last = (r == H - 2 && c == W - 2) ? 1 : 0;
        exp_q.push_back(e);
      end
  endtask

  task automatic fill(input int kind);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        case (kind)
          0: img[r][c] = 8'd100;
          1: img[r][c] = (c < 32) ? 8'd0 : 8'd255;
          2: img[r][c] = 8'(c);
          default: img[r][c] = 8'($urandom_range(255));
        endcase
  endtask

  // Drive npix accepts of the current image; mode switches to m2 from pixel index sw onward.
  task automatic drive_frame(input int m, input int m2, input int sw, input int npix,
                             input int vprob, input int rprob);
    bit acc;
    int tries;
    strict = (rprob >= 100);
    build_expected(m);
    for (int idx = 0; idx < npix; idx++) begin
      tries = 0;
      do begin
        @(posedge clk);
        #1;
        mode      = 2'((idx >= sw) ? m2 : m);
        in_pix    = img[idx / W][idx % W];
        in_valid  = ($urandom_range(99) < vprob);
        out_ready = ($urandom_range(99) < rprob);
        @(negedge clk);
        acc = in_valid && in_ready;
        tries++;
        if (tries > 500) begin
          $display("FAIL accept_timeout: got 0 accepts, expected 1 (pixel %0d)", idx);
          $fatal(1, "accept timeout");
        end
      end while (!acc);
    end
  endtask

  task automatic idle_drain();
    int n = 0;
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while (exp_q.size() != 0 && n < 3000) begin
      @(posedge clk);
      n++;
    end
    repeat (3) @(posedge clk);
    check("drain_remaining", exp_q.size(), 0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  always @(negedge clk) begin
    exp_t e;
    int   l;
    bit   s;
    if (rst !== 1'b0) begin
      exp_q.delete();
      lat_q.delete();
      strict_q.delete();
      trow = 0; tcol = 0; out_cnt = 0;
      prev_stall = 1'b0;
    end else begin
      if (prev_stall)
        check("hold_during_stall", int'({out_valid, out_last, out_pix}), prev_word);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_output_pix", int'(out_pix), -1);
        end else begin
          e = exp_q.pop_front();
          l = lat_q.pop_front();
          s = strict_q.pop_front();
          check("out_pix", int'(out_pix), e.pix);
          check("out_last", int'(out_last), e.last);
          if (s) check("latency", cyc - l, 2);
          else   check("latency_min", int'(cyc - l >= 2), 1);
        end
        out_cnt++;
        if (out_last) begin
          check("outputs_per_frame", out_cnt, NOUT);
          out_cnt = 0;
        end
      end
      if (in_valid && in_ready) begin
        if (trow >= 2 && tcol >= 2) begin
          lat_q.push_back(cyc);
          strict_q.push_back(strict);
        end
        if (tcol == W - 1) begin
          tcol = 0;
          trow = (trow == H - 1) ? 0 : trow + 1;
        end else begin
          tcol++;
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_word  = int'({1'b1, out_last, out_pix});
    end
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; in_pix = 8'd0; mode = 2'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_out_valid", int'(out_valid), 0);
    check("reset_out_pix", int'(out_pix), 0);
    check("reset_out_last", int'(out_last), 0);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("reset_in_ready", int'(in_ready), 1);

    // Model pins against hand-computed values.
    fill(0);
    check("model_const_mode2", sobel(2, 10, 10), 0);
    fill(1);
    check("model_edge_col31", sobel(0, 1, 31), 255);
    check("model_edge_col32", sobel(0, 5, 32), 255);
    check("model_edge_col30", sobel(0, 1, 30), 0);
    check("model_edge_mode1", sobel(1, 5, 31), 0);
    fill(2);
    check("model_ramp_mode0", sobel(0, 3, 10), 8);
    check("model_ramp_mode3", sobel(3, 3, 10), 10);

    // Back-to-back frames with continuous input and a ready sink.
    fill(0); drive_frame(2, 2, W * H, W * H, 100, 100);
    fill(1); drive_frame(0, 0, W * H, W * H, 100, 100);
    drive_frame(1, 1, W * H, W * H, 100, 100);
    fill(2); drive_frame(0, 0, W * H, W * H, 100, 100);
    drive_frame(3, 3, W * H, W * H, 100, 100);
    idle_drain();

    // Random input bubbles and sink stalls.
    fill(9); drive_frame(2, 2, W * H, W * H, 70, 50);
    idle_drain();

    // Abort a frame after 1000 accepts, then a clean frame.
    fill(9); drive_frame(0, 0, W * H, 1000, 100, 100);
    do_reset();
    fill(9); drive_frame(2, 2, W * H, W * H, 100, 100);
    idle_drain();

    // Mode change mid-frame only takes effect on the next frame.
    fill(1); drive_frame(0, 1, 2000, W * H, 100, 100);
    drive_frame(1, 1, W * H, W * H, 100, 100);
    idle_drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sobel_stream_filter.md
SOBEL_STREAM_FILTER -- requirements
Module: sobel_stream_filter

Interface
REQ-001 The block SHALL have parameter IMG_WIDTH, default 64, pixels per row; legal range 4..4096.
REQ-002 The block SHALL have parameter IMG_HEIGHT, default 64, rows per frame; legal range 3..4096.
REQ-003 The block SHALL have parameter PIX_W, default 8, bits per pixel.
REQ-004 Port clk: input, 1 bit, the single clock; all state updates on its rising edge.
REQ-005 Port rst: input, 1 bit, reset; synchronous to clk and active-high.
REQ-006 Port in_pix: input, PIX_W bits, raster-order pixel (row 0 col 0 first).
REQ-007 Port in_valid: input, 1 bit, in_pix is valid.
REQ-008 Port in_ready: output, 1 bit, block accepts in_pix this cycle.
REQ-009 Port mode: input, 2 bits; 0 = |Gx|, 1 = |Gy|, 2 = |Gx|+|Gy|, 3 = window centre passthrough.
REQ-010 Port out_pix: output, PIX_W bits, filtered interior pixel.
REQ-011 Port out_valid: output, 1 bit, out_pix is valid.
REQ-012 Port out_ready: input, 1 bit, sink accepts out_pix.
REQ-013 Port out_last: output, 1 bit, qualifies the final output pixel of a frame.

Function
REQ-014 Handshake: a pixel is accepted when in_valid && in_ready; an output transfers when out_valid && out_ready.
REQ-015 in_ready SHALL equal !(out_valid && !out_ready); the whole pipeline stalls while out_valid is high and out_ready is low.
REQ-016 Position counters col (0..IMG_WIDTH-1) and row (0..IMG_HEIGHT-1) SHALL advance only on accept; col wraps to 0 and increments row; at (IMG_HEIGHT-1, IMG_WIDTH-1) both wrap to 0.
REQ-017 Two line buffers of IMG_WIDTH x PIX_W SHALL hold the previous two rows; a 3x3 window register SHALL shift one column per accept.
REQ-018 A window is complete when the accepted pixel has row>=2 and col>=2; it is centred at (row-1, col-1).
REQ-019 Exactly (IMG_WIDTH-2)*(IMG_HEIGHT-2) outputs per frame; border pixels produce no output.
REQ-020 Latency: a pixel accepted at cycle t that completes a window SHALL give out_valid at cycle t+2 with no stall; stalls add cycles one for one.
REQ-021 With window p[r][c] (r,c in 0..2, r=0 oldest row, c=0 oldest column): Gx = (p02+2p12+p22)-(p00+2p10+p20), Gy = (p20+2p21+p22)-(p00+2p01+p02), signed PIX_W+4 bits, no overflow.
REQ-022 Modes 0/1: out_pix = min(|G|, 2^PIX_W-1); mode 2: out_pix = min(|Gx|+|Gy|, 2^PIX_W-1); mode 3: out_pix = p11.
REQ-023 mode SHALL be latched when pixel (0,0) is accepted and held for the whole frame; changes mid-frame are ignored.
REQ-024 out_last SHALL be high only with the output centred at (IMG_HEIGHT-2, IMG_WIDTH-2).
REQ-025 Back-to-back frames SHALL stream with no bubble; the next frame's (0,0) may be accepted in the cycle after the previous frame's last pixel.
REQ-026 out_pix, out_valid and out_last SHALL hold stable while out_valid && !out_ready.
REQ-027 in_valid low SHALL insert bubbles only; no state advances without accept.

Reset
REQ-028 While rst is high: col=0, row=0, out_valid=0, out_last=0, out_pix=0, latched mode=0, window valid flags cleared; in_ready=1 from the first cycle after reset.
REQ-029 Line-buffer contents need not be reset; rows 0..1 of each frame overwrite them before use.
REQ-030 rst asserted mid-frame SHALL abort the frame; the first accept after rst deasserts is pixel (0,0) of a new frame.

Verification
REQ-031 Constant 100 image, 64x64, mode 2, out_ready=1 -> 3844 outputs all 0, out_last on the final one only.
REQ-032 Vertical edge (cols<32 = 0, else 255), mode 0 -> out_pix 255 at centre cols 31 and 32, 0 elsewhere; mode 1 -> all 0.
REQ-033 Horizontal ramp pixel=col, mode 0 -> every output 8 (Gx=8); mode 3 -> out_pix equals centre col index.
REQ-034 Random out_ready (50%) with random in_valid -> output stream identical to the no-stall run; outputs held stable during stalls; first output at t+2 of its completing accept.
REQ-035 rst pulsed after 1000 accepts, then full frame -> no output from the aborted frame after reset; new frame output matches golden model.
REQ-036 mode switched 0->1 mid-frame -> current frame all mode 0; next frame mode 1.
